// File: rtl/demux_scan_pkg.sv
// Shared types and helpers for the demux scan sequencer.
package demux_scan_pkg;

  localparam int CH_W   = 3;
  localparam int NUM_CH = 1 << CH_W;

  // Scan phases. The ST_ prefix keeps ST_GAP from colliding with the GAP parameter.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Returns {wrap, idx}. idx is the lowest enabled channel above cur. If no
  // such channel exists, idx is the lowest enabled channel and wrap is set.
  // A zero mask returns {1, 0}.
  function automatic logic [CH_W:0] next_ch(input logic [NUM_CH-1:0] mask,
                                            input logic [CH_W-1:0]   cur);
    logic [CH_W-1:0] above;
    logic [CH_W-1:0] lowest;
    logic            hit;
    above  = '0;
    lowest = '0;
    hit    = 1'b0;
    // Scan downward so the final assignment is the lowest matching index.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask[k]) begin
        lowest = CH_W'(k);
        if (k > int'(cur)) begin
          above = CH_W'(k);
          hit   = 1'b1;
        end
      end
    end
    return hit ? {1'b0, above} : {1'b1, lowest};
  endfunction

endpackage

// File: rtl/demux_scan_next.sv
// Combinational next-enabled-channel search.
module demux_scan_next
  import demux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  output logic              wrap,
  output logic [CH_W-1:0]   idx
);

  // Priority search above cur, wrapping to the lowest enabled channel.
  always_comb begin
    {wrap, idx} = next_ch(mask, cur);
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Round-robin scan sequencer driving the select and data input of a 1-to-8 demux.
module demux_scan_ctrl
  import demux_scan_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int GAP   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_CH-1:0]    en_mask,
  input  logic [CNT_W-1:0]     dwell,
  input  logic                 din,
  output logic                 i,
  output logic [CH_W-1:0]      s,
  output logic                 busy,
  output logic                 ch_done,
  output logic                 frame_done
);

  // Gap counter reuses the dwell counter, so it is loaded with GAP-1.
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  state_t              state_reg, state_next;
  logic [NUM_CH-1:0]   shadow_reg, shadow_next;
  logic [CH_W-1:0]     cur_reg, cur_next;
  logic [CH_W-1:0]     nxt_reg, nxt_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                stop_pend_reg, stop_pend_next;

  logic                adv_wrap;
  logic [CH_W-1:0]     adv_idx;
  logic                low_wrap_unused;
  logic [CH_W-1:0]     low_idx;
  logic [CNT_W-1:0]    dwell_load;
  logic                stop_now;

  // Successor of the current channel within the frame's shadow mask.
  demux_scan_next u_adv (
    .mask (shadow_reg),
    .cur  (cur_reg),
    .wrap (adv_wrap),
    .idx  (adv_idx)
  );

  // Searching above the top channel always wraps, yielding the lowest enabled
  // channel of the live mask (first channel of a new frame).
  demux_scan_next u_low (
    .mask (en_mask),
    .cur  ({CH_W{1'b1}}),
    .wrap (low_wrap_unused),
    .idx  (low_idx)
  );

  assign dwell_load = (dwell == '0) ? '0 : dwell - 1'b1;
  assign stop_now   = stop_pend_reg | stop;

  // Select is the channel index with its bits reversed (s[0] carries the MSB), zero when idle.
  generate
    for (genvar gi = 0; gi < CH_W; gi++) begin : g_sel
      assign s[gi] = busy & cur_reg[CH_W-1-gi];
    end
  endgenerate

  // State register and scan bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      shadow_reg    <= '0;
      cur_reg       <= '0;
      nxt_reg       <= '0;
      cnt_reg       <= '0;
      stop_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shadow_reg    <= shadow_next;
      cur_reg       <= cur_next;
      nxt_reg       <= nxt_next;
      cnt_reg       <= cnt_next;
      stop_pend_reg <= stop_pend_next;
    end
  end

  // Next-state logic, data gating and completion pulses.
  always_comb begin
    state_next     = state_reg;
    shadow_next    = shadow_reg;
    cur_next       = cur_reg;
    nxt_next       = nxt_reg;
    cnt_next       = cnt_reg;
    stop_pend_next = stop_pend_reg;
    busy           = (state_reg != ST_IDLE);
    i              = 1'b0;
    ch_done        = 1'b0;
    frame_done     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        stop_pend_next = 1'b0;
        if (start && !stop && (en_mask != '0)) begin
          shadow_next = en_mask;
          cur_next    = low_idx;
          cnt_next    = dwell_load;
          state_next  = ST_DWELL;
        end
      end

      ST_DWELL: begin
        i              = din;
        stop_pend_next = stop_now;
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          ch_done    = 1'b1;
          frame_done = adv_wrap;
          // A frame boundary reloads the mask and restarts from its lowest channel.
          if (adv_wrap) begin
            shadow_next = en_mask;
            nxt_next    = low_idx;
          end else begin
            nxt_next    = adv_idx;
          end
          if (stop_now || (adv_wrap && (en_mask == '0))) begin
            state_next     = ST_IDLE;
            stop_pend_next = 1'b0;
          end else if (GAP > 0) begin
            state_next = ST_GAP;
            cnt_next   = GAP_LOAD;
          end else begin
            state_next = ST_DWELL;
            cur_next   = adv_wrap ? low_idx : adv_idx;
            cnt_next   = dwell_load;
          end
        end
      end

      ST_GAP: begin
        stop_pend_next = stop_now;
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (stop_now) begin
          state_next     = ST_IDLE;
          stop_pend_next = 1'b0;
        end else begin
          state_next = ST_DWELL;
          cur_next   = nxt_reg;
          cnt_next   = dwell_load;
        end
      end

      default: begin
        state_next     = ST_IDLE;
        stop_pend_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Randomized and directed check of the scan sequencer, GAP=0 and GAP=1 side by side.
module tb_demux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, din;
  logic [7:0] en_mask, dwell;

  logic       i_g0, busy_g0, cd_g0, fd_g0;
  logic [2:0] s_g0;
  logic       i_g1, busy_g1, cd_g1, fd_g1;
  logic [2:0] s_g1;

  always #5 clk = ~clk;

  demux_scan_ctrl #(.CNT_W(8), .GAP(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en_mask(en_mask),
    .dwell(dwell), .din(din), .i(i_g0), .s(s_g0), .busy(busy_g0),
    .ch_done(cd_g0), .frame_done(fd_g0)
  );

  demux_scan_ctrl #(.CNT_W(8), .GAP(1)) dut_g1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en_mask(en_mask),
    .dwell(dwell), .din(din), .i(i_g1), .s(s_g1), .busy(busy_g1),
    .ch_done(cd_g1), .frame_done(fd_g1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, one slot per instance; the slot index equals that instance's gap length.
  // Each scan step is described by the channel in use, whether it is a gap,
  // and how many cycles of that step remain.
  logic       m_busy [2];
  logic       m_gap  [2];
  logic       m_stop [2];
  int         m_ch   [2];
  int         m_left [2];
  int         m_pend [2];
  logic [7:0] m_mask [2];
  logic       m_valid = 1'b0;

  function automatic int above(input logic [7:0] m, input int c);
    for (int k = c + 1; k < 8; k++) if (m[k]) return k;
    return -1;
  endfunction

  function automatic int lowest(input logic [7:0] m);
    for (int k = 0; k < 8; k++) if (m[k]) return k;
    return 0;
  endfunction

  function automatic int dw(input logic [7:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  task automatic model_step();
    int nx;
    logic boundary;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_busy[u] = 0; m_gap[u] = 0; m_stop[u] = 0;
        m_ch[u] = 0; m_left[u] = 0; m_pend[u] = 0; m_mask[u] = 0;
      end else if (!m_busy[u]) begin
        if (start && !stop && en_mask != 0) begin
          m_busy[u] = 1; m_gap[u] = 0; m_stop[u] = 0;
          m_mask[u] = en_mask; m_ch[u] = lowest(en_mask); m_left[u] = dw(dwell);
        end
      end else begin
        if (stop) m_stop[u] = 1;
        if (m_left[u] > 1) begin
          m_left[u]--;
        end else if (!m_gap[u]) begin
          nx = above(m_mask[u], m_ch[u]);
          boundary = (nx < 0);
          if (boundary) begin
            m_mask[u] = en_mask;
            nx = lowest(en_mask);
          end
          if (m_stop[u] || (boundary && en_mask == 0)) begin
            m_busy[u] = 0;
          end else if (u > 0) begin
            m_gap[u] = 1; m_left[u] = u; m_pend[u] = nx;
          end else begin
            m_ch[u] = nx; m_left[u] = dw(dwell);
          end
        end else begin
          if (m_stop[u]) m_busy[u] = 0;
          else begin
            m_ch[u] = m_pend[u]; m_gap[u] = 0; m_left[u] = dw(dwell);
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic       e_i, e_cd, e_fd, o_i, o_busy, o_cd, o_fd;
    logic [2:0] c, e_s, o_s;
    for (int u = 0; u < 2; u++) begin
      c    = 3'(m_ch[u]);
      e_s  = m_busy[u] ? {c[0], c[1], c[2]} : 3'b000;
      e_i  = (m_busy[u] && !m_gap[u]) ? din : 1'b0;
      e_cd = m_busy[u] && !m_gap[u] && (m_left[u] == 1);
      e_fd = e_cd && (above(m_mask[u], m_ch[u]) < 0);
      o_i    = (u == 0) ? i_g0    : i_g1;
      o_s    = (u == 0) ? s_g0    : s_g1;
      o_busy = (u == 0) ? busy_g0 : busy_g1;
      o_cd   = (u == 0) ? cd_g0   : cd_g1;
      o_fd   = (u == 0) ? fd_g0   : fd_g1;
      chk($sformatf("g%0d.busy", u),       o_busy, m_busy[u]);
      chk($sformatf("g%0d.s", u),          o_s,    e_s);
      chk($sformatf("g%0d.i", u),          o_i,    e_i);
      chk($sformatf("g%0d.ch_done", u),    o_cd,   e_cd);
      chk($sformatf("g%0d.frame_done", u), o_fd,   e_fd);
      if (u == 1 && e_cd)
        $display("txn g1 ch=%0d frame_done=%0d t=%0t", m_ch[u], e_fd, $time);
    end
  endtask

  // One clock: drive on the falling edge, check after settling, advance model on the rising edge.
  task automatic cycle(input logic r, input logic st, input logic sp,
                       input logic [7:0] m, input logic [7:0] d, input logic dn);
    @(negedge clk);
    rst_n = r; start = st; stop = sp; en_mask = m; dwell = d; din = dn;
    #1;
    if (m_valid) check_outputs();
    @(posedge clk);
    model_step();
    if (!r) m_valid = 1'b1;
  endtask

  task automatic run(input int n, input logic [7:0] m, input logic [7:0] d);
    repeat (n) cycle(1'b1, 1'b0, 1'b0, m, d, 1'($urandom_range(1)));
  endtask

  logic       stop_sent, saw_ch3;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; en_mask = '0; dwell = '0; din = 1'b0;

    // Reset held with start asserted.
    cycle(1'b0, 1'b1, 1'b0, 8'hA5, 8'd3, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 8'hA5, 8'd3, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'hA5, 8'd3, 1'b1);
    chk("reset_busy", {busy_g1, busy_g0}, 8'h00);

    // Mask 1010_0101, dwell 3, din high: ch 0,2,5,7 then wrap.
    cycle(1'b1, 1'b1, 1'b0, 8'hA5, 8'd3, 1'b1);
    repeat (40) cycle(1'b1, 1'b0, 1'b0, 8'hA5, 8'd3, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 8'hA5, 8'd3, 1'b1);
    run(12, 8'hA5, 8'd3);

    // Dwell 0 behaves as one cycle per channel.
    cycle(1'b1, 1'b1, 1'b0, 8'hA5, 8'd0, 1'b1);
    run(20, 8'hA5, 8'd0);
    cycle(1'b1, 1'b0, 1'b1, 8'hA5, 8'd0, 1'b0);
    run(6, 8'hA5, 8'd0);

    // Stop mid-dwell of ch 2 with mask 0F, dwell 4.
    stop_sent = 1'b0;
    saw_ch3   = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 8'h0F, 8'd4, 1'b1);
    for (int k = 0; k < 40; k++) begin
      logic sp;
      sp = !stop_sent && m_busy[1] && !m_gap[1] && m_ch[1] == 2 && m_left[1] == 3;
      if (sp) stop_sent = 1'b1;
      cycle(1'b1, 1'b0, sp, 8'h0F, 8'd4, 1'($urandom_range(1)));
      if (busy_g1 && s_g1 == 3'b110) saw_ch3 = 1'b1;
    end
    chk("stop_issued", stop_sent, 1'b1);
    chk("stop_no_ch3", saw_ch3, 1'b0);
    chk("stop_idle", busy_g1, 1'b0);

    // Mask changed mid-frame: frame finishes on 0F, next frame uses 80, then 0 ends the scan.
    cycle(1'b1, 1'b1, 1'b0, 8'h0F, 8'd2, 1'b1);
    run(3, 8'h0F, 8'd2);
    run(30, 8'h80, 8'd2);
    run(30, 8'h00, 8'd2);
    chk("mask0_idle", {busy_g1, busy_g0}, 8'h00);

    // Start with empty mask, start together with stop, reset mid-dwell.
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'd2, 1'b1);
    run(2, 8'h00, 8'd2);
    chk("empty_start", {busy_g1, busy_g0}, 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 8'hFF, 8'd2, 1'b1);
    run(2, 8'hFF, 8'd2);
    chk("start_stop", {busy_g1, busy_g0}, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'hFF, 8'd5, 1'b1);
    run(3, 8'hFF, 8'd5);
    cycle(1'b0, 1'b0, 1'b0, 8'hFF, 8'd5, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'hFF, 8'd5, 1'b1);
    chk("midscan_reset", {busy_g1, busy_g0, 2'b00, s_g1}, 8'h00);

    // Random traffic.
    begin
      logic [7:0] rm, rd;
      rm = 8'($urandom);
      rd = 8'($urandom_range(4));
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(15) == 0) rm = ($urandom_range(3) == 0) ? 8'(1 << $urandom_range(7)) : 8'($urandom);
        if ($urandom_range(7) == 0) rd = 8'($urandom_range(4));
        cycle(($urandom_range(199) != 0), ($urandom_range(7) == 0), ($urandom_range(31) == 0),
              rm, rd, 1'($urandom_range(1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
